mem_addr_filter: RTL and testbench
==================================

Name: mem_addr_filter

Overview:
Downstream consumer of the AHB slave's memory-side request bus (rd_en/wr_en/addr/wr_data).
- Checks each request against NUM_REGIONS programmable address windows with per-region read/write permission.
- Allowed requests access an internal word memory. Denied requests are blocked, flagged, captured and counted.
- Returns read data with fixed 1-cycle latency.

Parameters:
ADDR_WIDTH, 32, request address width (bytes)
DATA_WIDTH, 32, data word width
MEM_DEPTH, 256, memory words (power of 2)
NUM_REGIONS, 4, programmable filter windows
CNT_WIDTH, 16, violation counter width

Ports:
hclk  in  1  clock, rising edge
hresetn  in  1  async active-low reset
rd_en  in  1  read request this cycle
wr_en  in  1  write request this cycle
addr  in  ADDR_WIDTH  byte address of request
wr_data  in  DATA_WIDTH  write data, qualified by wr_en
rd_data  out  DATA_WIDTH  read return data
rd_valid  out  1  rd_data valid (one-cycle pulse per read)
cfg_we  in  1  region config write strobe
cfg_idx  in  $clog2(NUM_REGIONS)  region being written
cfg_en  in  1  region enable
cfg_base  in  ADDR_WIDTH  region lower bound, inclusive
cfg_limit  in  ADDR_WIDTH  region upper bound, inclusive
cfg_perm  in  2  bit0 read allowed, bit1 write allowed
err  out  1  one-cycle pulse: previous-cycle request denied
err_addr  out  ADDR_WIDTH  address of most recent denied request (held)
viol_cnt  out  CNT_WIDTH  saturating count of denied requests
viol_clr  in  1  synchronous clear of viol_cnt

Behaviour:
- Clocking and reset: single clock hclk; reset hresetn is asynchronous, active-low.
- Reset values: rd_data=0, rd_valid=0, err=0, err_addr=0, viol_cnt=0. All regions cleared (en=0, base=0, limit=0, perm=0). Every request after reset is therefore denied until configured. Memory array is not reset.
- Request sampling: a request exists in any cycle where rd_en|wr_en=1. Each such cycle is an independent request; held enables mean repeated requests.
- Region match:
  - Region i hits when en_i=1 and base_i <= addr <= limit_i (unsigned, full width).
  - The lowest-index hit wins; its perm is used.
  - base>limit never hits. No hit means denied.
- Deny conditions (any one):
  - rd_en and wr_en both 1 (protocol error, nothing performed)
  - addr[1:0]!=0 (misaligned)
  - no region hit
  - read with perm[0]=0
  - write with perm[1]=0
- Memory index: addr[$clog2(MEM_DEPTH)+1:2]; upper address bits are ignored for indexing (aliasing), but filtering uses the full address.
- Allowed write: mem[idx] <= wr_data at the same edge. No output response.
- Allowed read: at the next edge rd_valid=1 and rd_data=mem[idx].
  - A write in cycle N followed by a read of the same idx in cycle N+1 returns the new data.
- Denied read: at the next edge rd_valid=1, rd_data=0, err=1. The requester is never left hanging.
- Denied write: memory unchanged; err=1 at the next edge.
- Denied-request bookkeeping (every denied request):
  - err_addr <= addr at the next edge.
  - viol_cnt increments, saturating at all-ones.
  - viol_clr in the same cycle as a denial gives viol_cnt=1. viol_clr alone gives 0.
- rd_valid and err are deasserted in any cycle following a non-request or allowed-write cycle.
- Config writes:
  - cfg_we updates region cfg_idx at the edge.
  - A request in the same cycle uses the old config; the new config applies from the next cycle.
  - cfg_idx >= NUM_REGIONS is ignored.
- Reset mid-operation: a pending read response is dropped (rd_valid=0), and the config and counter return to reset values.
- No back-pressure: the block accepts a request every cycle, matching the upstream stage, which has no stall path.

Decomposition:
- Package mem_addr_filter_pkg:
  - region_cfg_t struct {en, base, limit, perm}
  - PERM_RD=0 and PERM_WR=1 bit indices
  - DENY_RDATA='0
- Sub-module mem_region_match: combinational priority matcher. Inputs are the region array and addr; outputs are hit and perm.
- The top level holds the config registers, memory array, response pipeline and error counter.

Test Plan:
- Reset, then write 0x10 with no regions configured -> err=1 next cycle, err_addr=0x10, viol_cnt=1.
- Region0 = 0x00..0xFF, perm=3; write 0xA5A5_0001 to 0x20, then read 0x20 next cycle -> rd_valid=1, rd_data=0xA5A5_0001 one cycle after the read, err=0.
- Region0 = 0x00..0xFF, perm=1 (read-only); write 0xDEAD to 0x40, then read 0x40 -> write denied (err=1), read returns the prior value and memory is unchanged.
- Overlap check, region0 = 0x100..0x1FF perm=1, region1 = 0x000..0xFFF perm=3:
  - write 0x180 -> denied (region0 wins)
  - write 0x080 -> allowed
- Boundaries with region0 = 0x100..0x1FF, perm=3:
  - addr 0x1FC -> allowed
  - addr 0x200 -> denied
  - addr 0x102 -> denied (misaligned)
  - rd_en=wr_en=1 -> denied, rd_valid=0
- Counter and reset behaviour:
  - Force 2^CNT_WIDTH+3 denials -> viol_cnt saturates at all-ones.
  - Denial with viol_clr -> viol_cnt=1.
  - Assert hresetn low in the cycle after a read -> rd_valid=0 and all config cleared.

Source files
------------

// File: rtl/mem_addr_filter_pkg.sv
// ----------------------------------------------------------------------------
// mem_addr_filter_pkg
// Shared types and constants for the memory address filter.
//   region_cfg_t : one programmable address window (enable, inclusive
//                  base/limit, read/write permission bits)
//   PERM_RD/WR   : bit positions inside region_cfg_t.perm
//   DENY_RDATA   : data returned for a denied read
// Base/limit are stored at MAX_ADDR_W bits so the struct is independent of
// the instantiating block's ADDR_WIDTH (supports ADDR_WIDTH <= 64).
// ----------------------------------------------------------------------------
package mem_addr_filter_pkg;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;

  localparam int PERM_RD = 0;
  localparam int PERM_WR = 1;

  localparam logic [MAX_DATA_W-1:0] DENY_RDATA = '0;

  typedef struct packed {
    logic                  en;
    logic [MAX_ADDR_W-1:0] base;
    logic [MAX_ADDR_W-1:0] limit;
    logic [1:0]            perm;
  } region_cfg_t;

endpackage

// File: rtl/mem_region_match.sv
// ----------------------------------------------------------------------------
// mem_region_match
// Combinational priority matcher over the programmed address windows.
// Ports:
//   regions : packed array of region configs, index 0 has highest priority
//   addr    : full-width byte address under test
//   hit     : some enabled region contains addr (base <= addr <= limit)
//   perm    : permission bits of the lowest-index hitting region (0 if none)
// A region with base > limit can never satisfy both compares, so it never hits.
// ----------------------------------------------------------------------------
module mem_region_match
  import mem_addr_filter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 4
) (
  input  region_cfg_t [NUM_REGIONS-1:0] regions,
  input  logic [ADDR_WIDTH-1:0]         addr,
  output logic                          hit,
  output logic [1:0]                    perm
);

  logic [MAX_ADDR_W-1:0] addr_ext;

  // NOTE: every output of a combinational block gets a default before the
  // conditional logic, otherwise an unassigned path infers a latch.
  always_comb begin
    hit      = 1'b0;
    perm     = '0;
    addr_ext = MAX_ADDR_W'(addr);
    // Walk from the highest index down so the lowest-index hit is the last
    // writer and therefore wins.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (regions[i].en &&
          (regions[i].base <= addr_ext) &&
          (addr_ext <= regions[i].limit)) begin
        hit  = 1'b1;
        perm = regions[i].perm;
      end
    end
  end

endmodule

// File: rtl/mem_addr_filter.sv
// ----------------------------------------------------------------------------
// mem_addr_filter
// Filters memory-side requests against NUM_REGIONS programmable windows,
// serves allowed requests from an internal word memory and records denials.
// Ports:
//   hclk, hresetn      : clock (rising edge), async active-low reset
//   rd_en, wr_en       : request strobes, one independent request per cycle
//   addr, wr_data      : byte address and write data of the request
//   rd_data, rd_valid  : read response, exactly one cycle after every read
//   cfg_we/idx/en/base/limit/perm : region configuration write port
//   err                : pulse, previous-cycle request was denied
//   err_addr           : address of most recent denied request (held)
//   viol_cnt, viol_clr : saturating denial counter and its sync clear
// ----------------------------------------------------------------------------
module mem_addr_filter
  import mem_addr_filter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_WIDTH   = 16,
  localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_limit,
  input  logic [1:0]            cfg_perm,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [CNT_WIDTH-1:0]  viol_cnt,
  input  logic                  viol_clr
);

  region_cfg_t [NUM_REGIONS-1:0] regions;
  logic [DATA_WIDTH-1:0]         mem [MEM_DEPTH];

  logic              hit;
  logic [1:0]        perm;
  logic              req;
  logic              deny;
  logic              perm_ok;
  logic              rd_ok;
  logic              wr_ok;
  logic [MEM_AW-1:0] idx;

  mem_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_match (
    .regions (regions),
    .addr    (addr),
    .hit     (hit),
    .perm    (perm)
  );

  // Upper address bits alias onto the memory; filtering still sees them.
  assign idx = addr[MEM_AW+1:2];

  always_comb begin
    req     = rd_en | wr_en;
    perm_ok = rd_en ? perm[PERM_RD] : perm[PERM_WR];
    // Simultaneous rd_en/wr_en is a protocol error: denied, nothing performed.
    deny    = req & ((rd_en & wr_en) | (addr[1:0] != 2'b00) | ~hit | ~perm_ok);
    rd_ok   = rd_en & ~deny;
    wr_ok   = wr_en & ~deny;
  end

  // Region configuration. A request in the same cycle sees the old values
  // because the matcher reads the registers, not the cfg_* inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      regions <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      regions[cfg_idx] <= '{en:    cfg_en,
                            base:  MAX_ADDR_W'(cfg_base),
                            limit: MAX_ADDR_W'(cfg_limit),
                            perm:  cfg_perm};
    end
  end

  // NOTE: the memory array has no reset; clearing it would turn the RAM into
  // a flop array. Only the control/response registers are reset.
  always_ff @(posedge hclk) begin
    if (wr_ok) begin
      mem[idx] <= wr_data;
    end
  end

  // Response pipeline: a read (allowed or denied) always gets rd_valid, a
  // protocol-error cycle is not a read and gets none.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      rd_valid <= rd_en & ~wr_en;
      rd_data  <= rd_ok ? mem[idx] : DENY_RDATA[DATA_WIDTH-1:0];
      err      <= deny;
      if (deny) begin
        err_addr <= addr;
      end
    end
  end

  // Violation counter: clear has priority but a coincident denial still counts.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      viol_cnt <= '0;
    end else if (viol_clr) begin
      viol_cnt <= deny ? CNT_WIDTH'(1) : '0;
    end else if (deny && (viol_cnt != '1)) begin
      viol_cnt <= viol_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_addr_filter.sv
// ----------------------------------------------------------------------------
// tb_mem_addr_filter
// Directed-vector bench for mem_addr_filter with hand-computed expectations.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the edge that registers the response.
// ----------------------------------------------------------------------------
module tb_mem_addr_filter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic          cfg_en;
  logic [AW-1:0] cfg_base, cfg_limit;
  logic [1:0]    cfg_perm;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] viol_cnt;
  logic          viol_clr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 hclk = ~hclk;

  mem_addr_filter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_DEPTH   (256),
    .NUM_REGIONS (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_base  (cfg_base),
    .cfg_limit (cfg_limit),
    .cfg_perm  (cfg_perm),
    .err       (err),
    .err_addr  (err_addr),
    .viol_cnt  (viol_cnt),
    .viol_clr  (viol_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; addr = '0; wr_data = '0;
    cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_base = '0; cfg_limit = '0; cfg_perm = '0;
    viol_clr = 0;
  endtask

  task automatic do_cfg(input logic [1:0] idx, input logic en,
                        input logic [AW-1:0] base, input logic [AW-1:0] limit,
                        input logic [1:0] perm);
    cfg_we = 1; cfg_idx = idx; cfg_en = en;
    cfg_base = base; cfg_limit = limit; cfg_perm = perm;
    tick();
    idle_inputs();
  endtask

  // One request cycle; on return the outputs reflect that request.
  task automatic do_req(input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    hresetn = 0;
    #12;
    check("rst_rd_data",  rd_data,  0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err",      err,      0);
    check("rst_err_addr", err_addr, 0);
    check("rst_viol_cnt", viol_cnt, 0);
    @(posedge hclk); #1;
    hresetn = 1;

    // No regions configured: everything denied.
    do_req(0, 1, 32'h10, 32'h1111);
    check("unconf_err",      err,      1);
    check("unconf_err_addr", err_addr, 32'h10);
    check("unconf_viol",     viol_cnt, 1);
    check("unconf_rvalid",   rd_valid, 0);

    // Full access window, write then read back.
    do_cfg(0, 1, 32'h0, 32'hFF, 2'b11);
    do_req(0, 1, 32'h20, 32'hA5A5_0001);
    check("wr_ok_err",    err,      0);
    check("wr_ok_rvalid", rd_valid, 0);
    do_req(0, 1, 32'h40, 32'h1234_5678);
    do_req(1, 0, 32'h20, 32'h0);
    check("rd_ok_valid", rd_valid, 1);
    check("rd_ok_data",  rd_data,  32'hA5A5_0001);
    check("rd_ok_err",   err,      0);
    tick();
    check("idle_rvalid", rd_valid, 0);
    check("idle_err",    err,      0);
    check("idle_viol",   viol_cnt, 1);

    // Read-only window: write denied, memory untouched.
    do_cfg(0, 1, 32'h0, 32'hFF, 2'b01);
    do_req(0, 1, 32'h40, 32'hDEAD);
    check("ro_wr_err",      err,      1);
    check("ro_wr_err_addr", err_addr, 32'h40);
    check("ro_wr_viol",     viol_cnt, 2);
    do_req(1, 0, 32'h40, 32'h0);
    check("ro_rd_data",  rd_data,  32'h1234_5678);
    check("ro_rd_valid", rd_valid, 1);
    check("ro_rd_err",   err,      0);

    // Overlap: region0 read-only inside region1 read/write; region0 wins.
    do_cfg(0, 1, 32'h100, 32'h1FF, 2'b01);
    do_cfg(1, 1, 32'h000, 32'hFFF, 2'b11);
    do_req(0, 1, 32'h180, 32'hBEEF);
    check("ovl_180_err",  err,      1);
    check("ovl_180_addr", err_addr, 32'h180);
    check("ovl_180_viol", viol_cnt, 3);
    do_req(0, 1, 32'h080, 32'h0000_0080);
    check("ovl_080_err", err, 0);
    do_req(1, 0, 32'h080, 32'h0);
    check("ovl_080_data", rd_data, 32'h0000_0080);
    do_req(1, 0, 32'h180, 32'h0);
    check("ovl_180_rd_err", err,      0);
    check("ovl_180_rd_vld", rd_valid, 1);

    // Boundaries against region0 = 0x100..0x1FF rw, other regions off.
    do_cfg(0, 1, 32'h100, 32'h1FF, 2'b11);
    do_cfg(1, 0, 32'h0, 32'h0, 2'b00);
    do_req(0, 1, 32'h1FC, 32'hCAFE_0001);
    check("bnd_1fc_wr_err", err, 0);
    do_req(1, 0, 32'h1FC, 32'h0);
    check("bnd_1fc_data", rd_data, 32'hCAFE_0001);
    check("bnd_1fc_err",  err,     0);
    do_req(1, 0, 32'h200, 32'h0);
    check("bnd_200_err",   err,      1);
    check("bnd_200_valid", rd_valid, 1);
    check("bnd_200_data",  rd_data,  0);
    check("bnd_200_addr",  err_addr, 32'h200);
    check("bnd_200_viol",  viol_cnt, 4);
    do_req(1, 0, 32'h102, 32'h0);
    check("misal_err",  err,      1);
    check("misal_data", rd_data,  0);
    check("misal_addr", err_addr, 32'h102);
    check("misal_viol", viol_cnt, 5);
    do_req(1, 1, 32'h104, 32'h5555);
    check("both_err",   err,      1);
    check("both_valid", rd_valid, 0);
    check("both_viol",  viol_cnt, 6);

    // base > limit never hits.
    do_cfg(2, 1, 32'h300, 32'h2FF, 2'b11);
    do_req(1, 0, 32'h300, 32'h0);
    check("inv_err",  err,      1);
    check("inv_viol", viol_cnt, 7);

    // Config write coincident with a request: old config applies.
    cfg_we = 1; cfg_idx = 3; cfg_en = 1; cfg_base = 32'h400; cfg_limit = 32'h4FF; cfg_perm = 2'b11;
    rd_en = 0; wr_en = 1; addr = 32'h400; wr_data = 32'h0400;
    tick();
    idle_inputs();
    check("cfg_same_err",  err,      1);
    check("cfg_same_viol", viol_cnt, 8);
    do_req(0, 1, 32'h400, 32'h0400);
    check("cfg_next_err", err, 0);

    // Counter clear.
    viol_clr = 1;
    tick();
    idle_inputs();
    check("clr_alone", viol_cnt, 0);
    viol_clr = 1; rd_en = 1; addr = 32'h3;
    tick();
    idle_inputs();
    check("clr_deny", viol_cnt, 1);

    // Saturation: count starts at 1, add 2^16+3 denials.
    wr_en = 1; addr = 32'h3;
    repeat ((1 << CW) + 3) @(posedge hclk);
    #1;
    check("sat_cnt", viol_cnt, {CW{1'b1}});
    check("sat_err", err,      1);
    idle_inputs();

    // Reset in the cycle after an allowed read.
    rd_en = 1; addr = 32'h1FC;
    @(posedge hclk);
    idle_inputs();
    #1;
    hresetn = 0;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_viol",  viol_cnt, 0);
    check("mid_rst_eaddr", err_addr, 0);
    @(posedge hclk); #1;
    hresetn = 1;
    do_req(1, 0, 32'h1FC, 32'h0);
    check("post_rst_err",   err,      1);
    check("post_rst_data",  rd_data,  0);
    check("post_rst_valid", rd_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
